// File: rtl/arbitro_ronda.sv
// arbitro_ronda: reaction-game referee for two players.
// Each round runs a pseudo-random DELAY, then ARMED (go light). The first
// button press in ARMED wins the round. Results are shown for MOSTRAR cycles,
// and the game ends after RONDAS rounds.
// Optional feature macro: ARBITRO_FALTA_EN. When it is defined, a press during
// DELAY is a foul and sends the block to the FOUL state.
module arbitro_ronda #(
  parameter int unsigned RONDAS      = 5,
  parameter int unsigned RETARDO_MIN = 16,
  parameter int unsigned VENTANA     = 255,
  parameter int unsigned MOSTRAR     = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       boton_a_i,
  input  logic       boton_b_i,
  output logic       led_verde_o,
  output logic       led_red_o,
  output logic       led_fin_o,
  output logic [1:0] ganador_o,
  output logic [3:0] puntos_a_o,
  output logic [3:0] puntos_b_o,
  output logic [3:0] ronda_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_ARMED, S_RESULT, S_FOUL, S_FIN
  } estado_t;

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] VENTANA_C = CW'(VENTANA);
  localparam logic [CW-1:0] MOSTRAR_C = CW'(MOSTRAR);
  localparam logic [CW-1:0] RETARDO_C = CW'(RETARDO_MIN);
  localparam logic [3:0]    RONDAS_C  = 4'(RONDAS);

  localparam logic [1:0] G_NADIE = 2'b00;
  localparam logic [1:0] G_A     = 2'b01;
  localparam logic [1:0] G_B     = 2'b10;

`ifdef ARBITRO_FALTA_EN
  localparam logic FALTA_EN = 1'b1;
`else
  localparam logic FALTA_EN = 1'b0;
`endif

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lfsr_q;
  logic          start_prev_q, a_prev_q, b_prev_q;
  logic          prio_b_q, prio_b_d;
  logic [1:0]    ganador_q, ganador_d;
  logic [3:0]    pa_q, pa_d, pb_q, pb_d, ronda_q, ronda_d;
  logic          verde_q, fin_q;

  logic          start_press, a_press, b_press;
  logic [CW-1:0] cnt_dec, delay_load;
  logic          gana_a, gana_b;

  function automatic logic [3:0] sat_inc(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  // A held level yields exactly one press on its first sampled cycle.
  assign start_press = start_i   & ~start_prev_q;
  assign a_press     = boton_a_i & ~a_prev_q;
  assign b_press     = boton_b_i & ~b_prev_q;

  assign cnt_dec    = cnt_q - CW'(1);
  assign delay_load = RETARDO_C + CW'(lfsr_q[3:0]);

  // Previous-level registers for the edge detectors.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_prev_q <= 1'b0;
      a_prev_q     <= 1'b0;
      b_prev_q     <= 1'b0;
    end else begin
      start_prev_q <= start_i;
      a_prev_q     <= boton_a_i;
      b_prev_q     <= boton_b_i;
    end
  end

  // Free-running Fibonacci LFSR x^8+x^6+x^5+x^4+1. It steps every cycle, so
  // the delay that gets loaded depends on when the players act.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Next-state and datapath decisions for the round sequencer.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    prio_b_d  = prio_b_q;
    ganador_d = ganador_q;
    pa_d      = pa_q;
    pb_d      = pb_q;
    ronda_d   = ronda_q;
    gana_a    = 1'b0;
    gana_b    = 1'b0;
    unique case (estado_q)
      S_IDLE, S_FIN: begin
        if (start_press) begin
          pa_d      = 4'd0;
          pb_d      = 4'd0;
          ronda_d   = 4'd0;
          ganador_d = G_NADIE;
          prio_b_d  = 1'b0;
          cnt_d     = delay_load;
          estado_d  = S_DELAY;
        end
      end
      S_DELAY: begin
        if (FALTA_EN && (a_press || b_press)) begin
          // Jumping the gun: the other player scores; a double foul scores nobody.
          cnt_d    = MOSTRAR_C;
          estado_d = S_FOUL;
          if (a_press && b_press) begin
            ganador_d = G_NADIE;
          end else if (a_press) begin
            ganador_d = G_B;
            pb_d      = sat_inc(pb_q);
            prio_b_d  = 1'b0;
          end else begin
            ganador_d = G_A;
            pa_d      = sat_inc(pa_q);
            prio_b_d  = 1'b1;
          end
        end else if (cnt_dec == '0) begin
          cnt_d    = VENTANA_C;
          estado_d = S_ARMED;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_ARMED: begin
        // A tie goes to the loser of the previous round.
        if (a_press && b_press) begin
          gana_a = ~prio_b_q;
          gana_b =  prio_b_q;
        end else begin
          gana_a = a_press;
          gana_b = b_press;
        end
        if (gana_a) begin
          ganador_d = G_A;
          pa_d      = sat_inc(pa_q);
          prio_b_d  = 1'b1;
          cnt_d     = MOSTRAR_C;
          estado_d  = S_RESULT;
        end else if (gana_b) begin
          ganador_d = G_B;
          pb_d      = sat_inc(pb_q);
          prio_b_d  = 1'b0;
          cnt_d     = MOSTRAR_C;
          estado_d  = S_RESULT;
        end else if (cnt_dec == '0) begin
          ganador_d = G_NADIE;
          cnt_d     = MOSTRAR_C;
          estado_d  = S_RESULT;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RESULT, S_FOUL: begin
        if (cnt_dec == '0) begin
          ronda_d = ronda_q + 4'd1;
          if (ronda_d == RONDAS_C) begin
            estado_d = S_FIN;
          end else begin
            cnt_d    = delay_load;
            estado_d = S_DELAY;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: estado_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      estado_q  <= S_IDLE;
      cnt_q     <= '0;
      prio_b_q  <= 1'b0;
      ganador_q <= G_NADIE;
      pa_q      <= 4'd0;
      pb_q      <= 4'd0;
      ronda_q   <= 4'd0;
      verde_q   <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      prio_b_q  <= prio_b_d;
      ganador_q <= ganador_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      ronda_q   <= ronda_d;
      verde_q   <= (estado_d == S_ARMED);
      fin_q     <= (estado_d == S_FIN);
    end
  end

`ifdef ARBITRO_FALTA_EN
  logic red_q;

  // Foul light follows the FOUL state, registered like the other lights.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) red_q <= 1'b0;
    else         red_q <= (estado_d == S_FOUL);
  end

  assign led_red_o = red_q;
`else
  assign led_red_o = 1'b0;
`endif

  assign led_verde_o = verde_q;
  assign led_fin_o   = fin_q;
  assign ganador_o   = ganador_q;
  assign puntos_a_o  = pa_q;
  assign puntos_b_o  = pb_q;
  assign ronda_o     = ronda_q;

endmodule

// File: doc/arbitro_ronda.md
ARBITRO_RONDA -- requirements
Module: arbitro_ronda

Interface
REQ-001 Parameter RONDAS, default 5, rounds per game (1..15).
REQ-002 Parameter RETARDO_MIN, default 16, minimum cycles in DELAY before go light.
REQ-003 Parameter VENTANA, default 255, cycles in ARMED before timeout.
REQ-004 Parameter MOSTRAR, default 8, cycles RESULT/FOUL is held.
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Start  input  1  synchronous level, rising edge starts/restarts game.
REQ-008 BotonA  input  1  synchronous level, player A button.
REQ-009 BotonB  input  1  synchronous level, player B button.
REQ-010 LedVerde  output  1  go light, high only in ARMED.
REQ-011 LedRED  output  1  foul light, high only in FOUL.
REQ-012 LedFin  output  1  game over, high only in FIN.
REQ-013 ganador  output  2  last round winner: 01 A, 10 B, 00 none.
REQ-014 puntosA / puntosB  output  4 each  player scores.
REQ-015 ronda  output  4  completed rounds in current game.

Function
REQ-016 Edge detect: press = level & ~previous level, one register per input; a held button yields one press.
REQ-017 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle in every state.
REQ-018 States: IDLE, DELAY, ARMED, RESULT, FOUL, FIN; all outputs registered.
REQ-019 IDLE/FIN: Start press -> clear puntosA, puntosB, ronda, ganador; load delay counter; go DELAY next cycle.
REQ-020 Start press in DELAY/ARMED/RESULT/FOUL ignored.
REQ-021 DELAY: counter loaded with RETARDO_MIN + lfsr[3:0]; decrements each cycle; at 0 -> ARMED, window counter loaded with VENTANA.
REQ-022 ARMED: first press wins, ganador set, winner score +1 -> RESULT.
REQ-023 ARMED simultaneous A and B press: priority to loser of previous round; priority A after reset or game start; tie is still a single winner.
REQ-024 ARMED window reaching 0 with no press: ganador=00, no score -> RESULT.
REQ-025 DELAY single press (foul): opposite player +1, ganador = opposite player -> FOUL; both pressed same cycle: no score, ganador=00 -> FOUL.
REQ-026 RESULT/FOUL held exactly MOSTRAR cycles; on exit ronda +1; ronda == RONDAS -> FIN, else DELAY with new delay load.
REQ-027 Presses during RESULT, FOUL, FIN, IDLE do not affect scores.
REQ-028 Scores saturate at 15; ronda never exceeds RONDAS.
REQ-029 Latency: press edge to ganador/score update = 1 cycle after the press is sampled.

Reset
REQ-030 Reset low asynchronously forces IDLE, LFSR=8'hA5, counters 0, priority A, all outputs 0, mid-operation included.
REQ-031 Leaving reset, first Start press is the only way out of IDLE.

Configuration
REQ-032 Macro ARBITRO_FALTA_EN defined: foul detection per REQ-025 and FOUL state present.
REQ-033 ARBITRO_FALTA_EN undefined: presses in DELAY ignored, FOUL unreachable, LedRED tied 0.

Verification (RONDAS=3, RETARDO_MIN=4, VENTANA=10, MOSTRAR=2)
REQ-034 Reset low during ARMED -> all outputs 0 immediately, IDLE; Start -> DELAY.
REQ-035 Start, BotonA pressed 3 cycles after LedVerde rises -> ganador=01, puntosA=1, after 2 cycles ronda=1, back in DELAY.
REQ-036 A and B pressed same cycle in ARMED, round 1 -> A wins; next round B lost so next tie -> B wins.
REQ-037 BotonB pressed in DELAY (macro on) -> LedRED for 2 cycles, puntosA+1, ganador=01; macro off -> no effect, ARMED follows.
REQ-038 No press in ARMED -> LedVerde high 10 cycles, ganador=00, scores unchanged.
REQ-039 Three rounds completed -> ronda=3, LedFin=1, Start pressed mid-game ignored, Start in FIN clears scores and ronda.
